// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Adds valid/ready request and response channels, sub-word access with extension, and RMW sub-word stores.
module dmem_lsu #(
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [DEPTH-1:0] dmem_addr,
    input  logic [31:0]      dmem_rdata,
    output logic [31:0]      dmem_wdata,
    output logic             dmem_we
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        lat_we;
    logic        lat_unsigned;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;

    logic        req_bad;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    // Upper address bits alias by design; fold them so the intent is explicit.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:DEPTH+2];

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores, both off the live memory word.
    always_comb begin
        ld_byte = dmem_rdata[{lat_off, 3'b000} +: 8];
        ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_size)
            SZ_BYTE: ld_ext = {{24{~lat_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{~lat_unsigned & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
        merged = dmem_rdata;
        if (lat_size == SZ_BYTE)
            merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
        else if (lat_off[1])
            merged[31:16] = lat_wdata;
        else
            merged[15:0] = lat_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'd0;
            lat_off      <= 2'd0;
            lat_wdata    <= 16'd0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= 32'd0;
            dmem_we      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we       <= req_we;
                        lat_unsigned <= req_unsigned;
                        lat_size     <= req_size;
                        lat_off      <= req_addr[1:0];
                        lat_wdata    <= req_wdata[15:0];
                        dmem_addr    <= req_addr[DEPTH+1:2];
                        resp_rdata   <= 32'd0;
                        resp_err     <= req_bad;
                        req_ready    <= 1'b0;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_size == SZ_WORD) begin
                            dmem_wdata <= req_wdata;
                            dmem_we    <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (lat_we) begin
                        dmem_wdata <= merged;
                        dmem_we    <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        resp_rdata <= ld_ext;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    dmem_we    <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // No accept here: req_ready only rises once the handshake has retired the response.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, multi-cycle corner sequences,
// and randomized transactions against a byte-lane arithmetic reference model.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_rdata;
    logic [31:0] dmem_wdata;
    logic        dmem_we;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_val;

    int checks = 0;
    int errors = 0;

    dmem_lsu #(.DEPTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dmem_addr    (dmem_addr),
        .dmem_rdata   (dmem_rdata),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, posedge write; preload port used only during reset.
    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) begin
        if (load_en)
            mem[load_idx] <= load_val;
        else if (dmem_we)
            mem[dmem_addr] <= dmem_wdata;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we_at;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        load_idx = 10'(idx);
        load_val = val;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference: treat the word as four byte lanes and compute results with plain arithmetic.
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat, output int we_at);
        int off, w, nbits;
        longint unsigned mask, old, v, nw;
        off   = int'(addr % 4);
        w     = int'((addr / 4) % 1024);
        err   = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && off != 0);
        rdata = 32'd0;
        lat   = 1;
        we_at = 0;
        if (err) return;
        nbits = 8 << size;
        mask  = (64'd1 << nbits) - 64'd1;
        old   = 64'(ref_mem[w]);
        if (!we) begin
            v = (old >> (8 * off)) & mask;
            if (!uns && nbits < 32 && v >= (mask + 64'd1) / 2)
                v = v + 64'hFFFF_FFFF - mask;
            rdata = v[31:0];
            lat   = 2;
        end else begin
            nw = (old & ~(mask << (8 * off))) | ((64'(wdata) & mask) << (8 * off));
            ref_mem[w] = nw[31:0];
            lat   = (nbits == 32) ? 2 : 3;
            we_at = lat - 1;
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int we_cnt, output int we_at);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        lat    = 0;
        we_cnt = 0;
        we_at  = 0;
        do begin
            tick();
            if (lat == 0) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_size  = 2'($urandom_range(0, 3));
                req_we    = 1'($urandom_range(0, 1));
            end
            lat++;
            if (dmem_we) begin
                we_cnt++;
                we_at = lat;
            end
        end while (!resp_valid && lat < 10);
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat, we_cnt, we_at, exp_lat, exp_we_at;
        int          hold_we, lat2;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'd0; resp_ready = 1'b0;
        load_en = 1'b0; load_idx = 10'd0; load_val = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(3, 32'h1122_3344);
        preload(5, 32'h8899_AABB);
        preload(8, 32'hA5A5_A5A5);

        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_dmem_we",    {31'd0, dmem_we},    32'd0);
        check("rst_dmem_addr",  {22'd0, dmem_addr},  32'd0);
        check("rst_dmem_wdata", dmem_wdata,          32'd0);
        rst = 1'b0;

        //          we    addr          sz    uns   wdata          rdata          err  lat we_at
        vecs[0]  = '{1'b0, 32'h0000_0016, 2'd0, 1'b0, 32'h0,        32'hFFFF_FF99, 1'b0, 2, 0};
        vecs[1]  = '{1'b0, 32'h0000_0014, 2'd1, 1'b1, 32'h0,        32'h0000_AABB, 1'b0, 2, 0};
        vecs[2]  = '{1'b0, 32'h0000_0014, 2'd2, 1'b0, 32'h0,        32'h8899_AABB, 1'b0, 2, 0};
        vecs[3]  = '{1'b1, 32'h0000_000D, 2'd0, 1'b0, 32'h0000_00EE, 32'h0,        1'b0, 3, 2};
        vecs[4]  = '{1'b0, 32'h0000_000C, 2'd2, 1'b0, 32'h0,        32'h1122_EE44, 1'b0, 2, 0};
        vecs[5]  = '{1'b1, 32'h0000_0003, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,        1'b1, 1, 0};
        vecs[6]  = '{1'b0, 32'h0000_0001, 2'd1, 1'b0, 32'h0,        32'h0,         1'b1, 1, 0};
        vecs[7]  = '{1'b0, 32'h0000_000C, 2'd2, 1'b0, 32'h0,        32'h1122_EE44, 1'b0, 2, 0};
        vecs[8]  = '{1'b0, 32'h0000_0010, 2'd3, 1'b0, 32'h0,        32'h0,         1'b1, 1, 0};
        vecs[9]  = '{1'b1, 32'h0000_0010, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 0};
        vecs[10] = '{1'b1, 32'h0000_0016, 2'd1, 1'b0, 32'h1234_CAFE, 32'h0,        1'b0, 3, 2};
        vecs[11] = '{1'b0, 32'h0000_0016, 2'd1, 1'b0, 32'h0,        32'hFFFF_CAFE, 1'b0, 2, 0};
        vecs[12] = '{1'b0, 32'h0000_1014, 2'd2, 1'b0, 32'h0,        32'hCAFE_AABB, 1'b0, 2, 0};
        vecs[13] = '{1'b1, 32'h0000_0020, 2'd2, 1'b0, 32'h1234_5678, 32'h0,        1'b0, 2, 1};
        vecs[14] = '{1'b0, 32'h0000_0023, 2'd0, 1'b1, 32'h0,        32'h0000_0012, 1'b0, 2, 0};
        vecs[15] = '{1'b0, 32'h0000_0020, 2'd0, 1'b0, 32'h0,        32'h0000_0078, 1'b0, 2, 0};
        vecs[16] = '{1'b0, 32'h0000_0022, 2'd1, 1'b0, 32'h0,        32'h0000_1234, 1'b0, 2, 0};
        vecs[17] = '{1'b0, 32'h0000_0017, 2'd0, 1'b1, 32'h0,        32'h0000_00CA, 1'b0, 2, 0};
        vecs[18] = '{1'b0, 32'h0000_0016, 2'd2, 1'b0, 32'h0,        32'h0,         1'b1, 1, 0};
        vecs[19] = '{1'b0, 32'h0000_0014, 2'd0, 1'b0, 32'h0,        32'hFFFF_FFBB, 1'b0, 2, 0};

        for (int i = 0; i < 20; i++) begin
            model(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                  exp_rd, exp_er, exp_lat, exp_we_at);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                    rd, er, lat, we_cnt, we_at);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we_at", i), 32'(we_at), 32'(vecs[i].exp_we_at));
            check($sformatf("vec%0d_we_cnt", i), 32'(we_cnt), (vecs[i].exp_we_at != 0) ? 32'd1 : 32'd0);
        end
        check("mem3_after_rmw", mem[3], 32'h1122_EE44);
        check("mem5_after_rmw", mem[5], 32'hCAFE_AABB);

        // Response held off: outputs frozen, no accept, then back-to-back with req_valid held high.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_size = 2'd0; req_unsigned = 1'b0;
        tick();
        req_addr = 32'h14; req_size = 2'd2;
        lat2 = 1;
        while (!resp_valid && lat2 < 10) begin
            tick();
            lat2++;
        end
        check("hold_lat", 32'(lat2), 32'd2);
        hold_we = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (dmem_we) hold_we++;
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_resp_rdata", resp_rdata, 32'hFFFF_FFBB);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        check("hold_no_write", 32'(hold_we), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("b2b_resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        check("b2b_no_accept_in_resp", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b_accepted", {31'd0, req_ready}, 32'd0);
        lat2 = 1;
        while (!resp_valid && lat2 < 10) begin
            tick();
            lat2++;
        end
        check("b2b_lat", 32'(lat2), 32'd2);
        check("b2b_rdata", resp_rdata, 32'hCAFE_AABB);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset while a halfword store sits in READ: no write, request dropped.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h22; req_size = 2'd1; req_wdata = 32'h0000_5555;
        tick();
        req_valid = 1'b0;
        check("rmo_in_read", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        tick();
        check("rmo_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rmo_req_ready", {31'd0, req_ready}, 32'd1);
        check("rmo_resp_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        hold_we = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (dmem_we || resp_valid) hold_we++;
        end
        check("rmo_quiet_after", 32'(hold_we), 32'd0);
        check("rmo_mem8", mem[8], 32'h1234_5678);

        // Randomized traffic over 16 words, with occasional aliasing upper address bits.
        for (int t = 0; t < 200; t++) begin
            logic [31:0] a, wd;
            logic [1:0]  sz;
            logic        w, u;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F000);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            wd = $urandom;
            model(w, a, sz, u, wd, exp_rd, exp_er, exp_lat, exp_we_at);
            run_txn(w, a, sz, u, wd, rd, er, lat, we_cnt, we_at);
            check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            check($sformatf("rnd%0d_err", t), {31'd0, er}, {31'd0, exp_er});
            check($sformatf("rnd%0d_lat", t), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_we_at", t), 32'(we_at), 32'(exp_we_at));
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
